// File: rtl/shift_reg_chain_output.sv
// Serial driver for NUM_BYTES daisy-chained 74HC595-style registers with start/busy/done handshake.
// Optional macro SHIFT_REG_OE_PWM_EN adds a 16-step PWM on the registers' active-low output enable.
module shift_reg_chain_output #(
    parameter int NUM_BYTES = 2,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [8*NUM_BYTES-1:0] i_value,
    input  logic                   i_start,
`ifdef SHIFT_REG_OE_PWM_EN
    input  logic [3:0]             i_brightness,
    output logic                   o_output_enable_n,
`endif
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_data_val,
    output logic                   o_data_clock,
    output logic                   o_latch_shifted_value
);

    localparam int W     = 8 * NUM_BYTES;
    localparam int DIV_W = ($clog2(CLK_DIV + 1) > 1) ? $clog2(CLK_DIV + 1) : 1;
    localparam int BIT_W = ($clog2(W) > 1) ? $clog2(W) : 1;
    localparam bit MSB   = (MSB_FIRST != 0);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LATCH    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [DIV_W-1:0]   div_cnt_r, div_cnt_s;
    logic [BIT_W-1:0]   bit_cnt_r, bit_cnt_s;
    logic [W-1:0]       shift_r, shift_s;

    logic busy_r, done_r, data_val_r, data_clock_r, latch_r;

    // Bit presented on DS for the current position of the shift register.
    function automatic logic head_bit(input logic [W-1:0] word);
        if (MSB) begin
            return word[W-1];
        end else begin
            return word[0];
        end
    endfunction

    // Shift register advanced by one position towards the head bit.
    function automatic logic [W-1:0] advance(input logic [W-1:0] word);
        if (MSB) begin
            return {word[W-2:0], 1'b0};
        end else begin
            return {1'b0, word[W-1:1]};
        end
    endfunction

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_s   = state_r;
        div_cnt_s = div_cnt_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        case (state_r)
            // DONE accepts a new start so back-to-back transfers only lose one cycle.
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_s   = ST_SHIFT_LO;
                    div_cnt_s = {DIV_W{1'b0}};
                    bit_cnt_s = {BIT_W{1'b0}};
                    shift_s   = i_value;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SHIFT_LO: begin
                if (div_cnt_r == DIV_LAST) begin
                    state_s   = ST_SHIFT_HI;
                    div_cnt_s = {DIV_W{1'b0}};
                end else begin
                    div_cnt_s = div_cnt_r + DIV_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_s = {DIV_W{1'b0}};
                    if (bit_cnt_r == BIT_LAST) begin
                        state_s = ST_LATCH;
                    end else begin
                        state_s   = ST_SHIFT_LO;
                        bit_cnt_s = bit_cnt_r + BIT_W'(1);
                        shift_s   = advance(shift_r);
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (div_cnt_r == DIV_LAST) begin
                    state_s   = ST_DONE;
                    div_cnt_s = {DIV_W{1'b0}};
                end else begin
                    div_cnt_s = div_cnt_r + DIV_W'(1);
                end
            end
            default: begin
                state_s   = ST_IDLE;
                div_cnt_s = {DIV_W{1'b0}};
                bit_cnt_s = {BIT_W{1'b0}};
                shift_s   = {W{1'b0}};
            end
        endcase
    end

    // State registers plus outputs registered from the next-state decode.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r      <= ST_IDLE;
            div_cnt_r    <= {DIV_W{1'b0}};
            bit_cnt_r    <= {BIT_W{1'b0}};
            shift_r      <= {W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            data_val_r   <= 1'b0;
            data_clock_r <= 1'b0;
            latch_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            div_cnt_r    <= div_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            busy_r       <= (state_s == ST_SHIFT_LO) || (state_s == ST_SHIFT_HI) ||
                            (state_s == ST_LATCH);
            done_r       <= (state_s == ST_DONE);
            data_val_r   <= ((state_s == ST_SHIFT_LO) || (state_s == ST_SHIFT_HI)) ?
                            head_bit(shift_s) : 1'b0;
            data_clock_r <= (state_s == ST_SHIFT_HI);
            latch_r      <= (state_s == ST_LATCH);
        end
    end

    assign o_busy                = busy_r;
    assign o_done                = done_r;
    assign o_data_val            = data_val_r;
    assign o_data_clock          = data_clock_r;
    assign o_latch_shifted_value = latch_r;

`ifdef SHIFT_REG_OE_PWM_EN
    logic [3:0] pwm_cnt_r;
    logic       oe_n_r;

    // Free-running PWM counter and registered active-low output enable.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pwm_cnt_r <= 4'd0;
            oe_n_r    <= 1'b1;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 4'd1;
            oe_n_r    <= (pwm_cnt_r >= i_brightness);
        end
    end

    assign o_output_enable_n = oe_n_r;
`endif

endmodule

// File: tb/tb_shift_reg_chain_output.sv
// Self-checking bench: cycle-exact reference model of a 16-bit MSB-first chain plus
// a 74HC595 chain model, and a second 8-bit LSB-first instance checked by bit stream.
module tb_shift_reg_chain_output;

    localparam int NB_A     = 2;
    localparam int DIV_A    = 2;
    localparam int W_A      = 8 * NB_A;
    localparam int T_DONE_A = (2 * W_A + 1) * DIV_A;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [W_A-1:0] value_a;
    logic           start_a;
    logic           busy_a, done_a, dval_a, dclk_a, latch_a;
    logic [7:0]     value_b;
    logic           start_b;
    logic           busy_b, done_b, dval_b, dclk_b, latch_b;
`ifdef SHIFT_REG_OE_PWM_EN
    logic [3:0]     brightness_a;
    logic           oe_n_a, oe_n_b;
`endif

    shift_reg_chain_output #(.NUM_BYTES(NB_A), .CLK_DIV(DIV_A), .MSB_FIRST(1)) u_dut_a (
        .i_clk                 (clk),
        .i_reset_n             (rst_n),
        .i_value               (value_a),
        .i_start               (start_a),
`ifdef SHIFT_REG_OE_PWM_EN
        .i_brightness          (brightness_a),
        .o_output_enable_n     (oe_n_a),
`endif
        .o_busy                (busy_a),
        .o_done                (done_a),
        .o_data_val            (dval_a),
        .o_data_clock          (dclk_a),
        .o_latch_shifted_value (latch_a)
    );

    shift_reg_chain_output #(.NUM_BYTES(1), .CLK_DIV(1), .MSB_FIRST(0)) u_dut_b (
        .i_clk                 (clk),
        .i_reset_n             (rst_n),
        .i_value               (value_b),
        .i_start               (start_b),
`ifdef SHIFT_REG_OE_PWM_EN
        .i_brightness          (4'd0),
        .o_output_enable_n     (oe_n_b),
`endif
        .o_busy                (busy_b),
        .o_done                (done_b),
        .o_data_val            (dval_b),
        .o_data_clock          (dclk_b),
        .o_latch_shifted_value (latch_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycles since acceptance (-1 = idle) and the captured word.
    int             m_t = -1;
    logic [W_A-1:0] m_word = '0;
    // 74HC595 chain model driven from the observed serial outputs.
    logic [W_A-1:0] chain_a = '0;
    logic [W_A-1:0] disp_a = '0;
    logic           prev_dclk_a = 1'b0;
    logic           prev_latch_a = 1'b0;

    typedef struct {
        logic [W_A-1:0] value;
        int             exp_busy;
        logic [W_A-1:0] exp_disp;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance the model at the rising edge, compare at the falling edge.
    task automatic step();
        logic [4:0] exp_v;
        int k, ph;
        @(posedge clk);
        if (!rst_n) begin
            m_t = -1;
        end else if (m_t < 0 || m_t == T_DONE_A) begin
            if (start_a) begin
                m_t = 0;
                m_word = value_a;
            end else begin
                m_t = -1;
            end
        end else begin
            m_t++;
        end
        @(negedge clk);
        exp_v = 5'b00000;
        if (m_t >= 0 && m_t < 2 * W_A * DIV_A) begin
            k  = m_t / (2 * DIV_A);
            ph = m_t % (2 * DIV_A);
            exp_v = {1'b1, 1'b0, m_word[W_A-1-k], (ph >= DIV_A), 1'b0};
        end else if (m_t >= 0 && m_t < T_DONE_A) begin
            exp_v = 5'b10001;
        end else if (m_t == T_DONE_A) begin
            exp_v = 5'b01000;
        end
        chk("cycle_outputs", 32'({busy_a, done_a, dval_a, dclk_a, latch_a}), 32'(exp_v));
        if (dclk_a && !prev_dclk_a) chain_a = {chain_a[W_A-2:0], dval_a};
        if (latch_a && !prev_latch_a) disp_a = chain_a;
        prev_dclk_a  = dclk_a;
        prev_latch_a = latch_a;
        if (m_t == T_DONE_A) chk("latched_word", 32'(disp_a), 32'(m_word));
    endtask

    task automatic run_vec(input vec_t v);
        int  busy_cnt;
        bit  done_seen;
        busy_cnt  = 0;
        done_seen = 1'b0;
        value_a = v.value;
        start_a = 1'b1;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            step();
            start_a = 1'b0;
            if (busy_a) busy_cnt++;
            if (done_a) done_seen = 1'b1;
        end
        chk("vec_done_seen", 32'(done_seen), 32'd1);
        chk("vec_busy_width", 32'(busy_cnt), 32'(v.exp_busy));
        chk("vec_display", 32'(disp_a), 32'(v.exp_disp));
    endtask

    task automatic run_b(input logic [7:0] v);
        int         busy_cnt, lat_cnt, nbits;
        bit         done_seen;
        logic       prev;
        logic [7:0] got;
        busy_cnt = 0; lat_cnt = 0; nbits = 0; done_seen = 1'b0; prev = 1'b0; got = 8'h00;
        value_b = v;
        start_b = 1'b1;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            step();
            start_b = 1'b0;
            if (busy_b) busy_cnt++;
            if (latch_b) lat_cnt++;
            if (dclk_b && !prev && nbits < 8) begin
                got[nbits] = dval_b;
                nbits++;
            end
            prev = dclk_b;
            if (done_b) done_seen = 1'b1;
        end
        chk("lsb_done_seen", 32'(done_seen), 32'd1);
        chk("lsb_busy_width", 32'(busy_cnt), 32'd17);
        chk("lsb_latch_width", 32'(lat_cnt), 32'd1);
        chk("lsb_bit_count", 32'(nbits), 32'd8);
        chk("lsb_bit_stream", 32'(got), 32'(v));
    endtask

    initial begin
        logic [W_A-1:0] saved;
        vecs[0] = '{value: 16'hA53C, exp_busy: 66, exp_disp: 16'hA53C};
        vecs[1] = '{value: 16'h0000, exp_busy: 66, exp_disp: 16'h0000};
        vecs[2] = '{value: 16'hFFFF, exp_busy: 66, exp_disp: 16'hFFFF};
        vecs[3] = '{value: 16'h8001, exp_busy: 66, exp_disp: 16'h8001};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; value_a = '0; value_b = 8'h00;
`ifdef SHIFT_REG_OE_PWM_EN
        brightness_a = 4'd0;
`endif
        #1;
        chk("reset_state_a", 32'({busy_a, done_a, dval_a, dclk_a, latch_a}), 32'd0);
        chk("reset_state_b", 32'({busy_b, done_b, dval_b, dclk_b, latch_b}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        run_b(8'h01);
        run_b(8'hA5);

        // Start held high while the word keeps changing: capture only at acceptance.
        start_a = 1'b1;
        for (int c = 0; c < 150; c++) begin
            value_a = W_A'($urandom);
            step();
        end
        start_a = 1'b0;
        repeat (80) step();

        // Reset in the middle of bit 5: outputs drop at once and no latch pulse follows.
        value_a = 16'h5A5A;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (5 * 2 * DIV_A) step();
        saved = disp_a;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", 32'({busy_a, done_a, dval_a, dclk_a, latch_a}), 32'd0);
        m_t = -1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (80) step();
        chk("reset_no_latch", 32'(disp_a), 32'(saved));
        run_vec(vecs[0]);

        for (int c = 0; c < 400; c++) begin
            start_a = ($urandom_range(0, 7) == 0);
            value_a = W_A'($urandom);
            step();
        end
        start_a = 1'b0;
        repeat (80) step();

`ifdef SHIFT_REG_OE_PWM_EN
        begin
            int lows;
            brightness_a = 4'd4;
            repeat (3) step();
            lows = 0;
            for (int c = 0; c < 32; c++) begin
                step();
                if (!oe_n_a) lows++;
            end
            chk("pwm_b4_lows", 32'(lows), 32'd8);
            brightness_a = 4'd0;
            repeat (3) step();
            lows = 0;
            for (int c = 0; c < 32; c++) begin
                step();
                if (!oe_n_a) lows++;
            end
            chk("pwm_b0_lows", 32'(lows), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
